// File: rtl/controle_formacao.sv
// Formation controller for the enemy array: scans enemy positions and alive flags,
// drives the shared movement clock CLOCK_MV and horizontal direction sentidoX.
module controle_formacao #(
    parameter int N_INIMIGOS    = 8,
    parameter int PERIODO_BASE  = 1000000,
    parameter int PASSO_PERIODO = 100000,
    parameter int PERIODO_MIN   = 200000,
    parameter int X_MIN_TELA    = 10,
    parameter int X_MAX_TELA    = 630,
    parameter int LARGURA       = 33,
    parameter int ALTURA        = 24,
    parameter int PASSO_X       = 2,
    parameter int Y_LIMITE      = 400
) (
    input  logic                              CLOCK_50,
    input  logic                              reset,
    input  logic                              pausa,
    input  logic                              reiniciarJogo,
    input  logic [10*N_INIMIGOS-1:0]          x_bus,
    input  logic [10*N_INIMIGOS-1:0]          y_bus,
    input  logic [N_INIMIGOS-1:0]             vivo_bus,
    output logic                              CLOCK_MV,
    output logic                              sentidoX,
    output logic [$clog2(N_INIMIGOS+1)-1:0]   vivos,
    output logic                              todos_mortos,
    output logic                              invasao
);

    localparam int VW = $clog2(N_INIMIGOS + 1);
    localparam int IW = (N_INIMIGOS > 1) ? $clog2(N_INIMIGOS) : 1;

    localparam logic [31:0] P_BASE   = 32'(PERIODO_BASE);
    localparam logic [31:0] P_PASSO  = 32'(PASSO_PERIODO);
    localparam logic [31:0] P_MIN    = 32'(PERIODO_MIN);
    localparam logic [31:0] P_N      = 32'(N_INIMIGOS);
    localparam logic [31:0] L_DIR    = 32'(LARGURA + PASSO_X);
    localparam logic [31:0] L_XMAX   = 32'(X_MAX_TELA);
    localparam logic [31:0] L_XMIN   = 32'(X_MIN_TELA + PASSO_X);
    localparam logic [31:0] L_YLIM   = 32'(Y_LIMITE);
    localparam logic [10:0] L_ALTURA = 11'(ALTURA);

    typedef enum logic {
        VARRE  = 1'b0,
        DECIDE = 1'b1
    } estado_t;

    // Unpacked views of the position buses
    logic [9:0] x_arr [N_INIMIGOS];
    logic [9:0] y_arr [N_INIMIGOS];

    generate
        for (genvar gi = 0; gi < N_INIMIGOS; gi++) begin : g_unpack
            assign x_arr[gi] = x_bus[10*gi +: 10];
            assign y_arr[gi] = y_bus[10*gi +: 10];
        end
    endgenerate

    estado_t        estado_reg, estado_next;
    logic [IW-1:0]  idx_reg;
    logic [9:0]     min_x_reg;
    logic [9:0]     max_x_reg;
    logic [10:0]    max_yb_reg;
    logic [VW-1:0]  cnt_reg;

    logic [VW-1:0]  vivos_reg;
    logic           todos_mortos_reg;
    logic           invasao_reg;
    logic           sentido_reg;
    logic           guarda_reg;
    logic [31:0]    periodo_pend_reg;

    logic [31:0]    contador_reg;
    logic [31:0]    periodo_reg;
    logic           clock_mv_reg;

    logic [9:0]     x_cur;
    logic [10:0]    yb_cur;
    logic           vivo_cur;
    logic           ultimo;
    logic [31:0]    mortos;
    logic [31:0]    reducao;
    logic [31:0]    periodo_calc;
    logic           borda_dir;
    logic           borda_esq;
    logic           mv_next;
    logic           queda;

    assign x_cur    = x_arr[idx_reg];
    assign yb_cur   = {1'b0, y_arr[idx_reg]} + L_ALTURA;
    assign vivo_cur = vivo_bus[idx_reg];
    assign ultimo   = (idx_reg == IW'(N_INIMIGOS - 1));

    always_comb begin
        estado_next = estado_reg;
        case (estado_reg)
            VARRE:   if (ultimo) estado_next = DECIDE;
            DECIDE:  estado_next = VARRE;
            default: estado_next = VARRE;
        endcase
    end

    // Period saturates at PERIODO_MIN; the compare is arranged so nothing underflows
    always_comb begin
        mortos       = P_N - 32'(cnt_reg);
        reducao      = mortos * P_PASSO;
        periodo_calc = (P_BASE < reducao + P_MIN) ? P_MIN : (P_BASE - reducao);
        borda_dir    = (32'(max_x_reg) + L_DIR) > L_XMAX;
        borda_esq    = 32'(min_x_reg) < L_XMIN;
    end

    always_comb begin
        mv_next = 1'b0;
        if (reiniciarJogo || todos_mortos_reg) begin
            mv_next = 1'b0;
        end else if (pausa) begin
            mv_next = clock_mv_reg;
        end else begin
            mv_next = (contador_reg < (periodo_reg >> 1));
        end
    end

    assign queda = clock_mv_reg & ~mv_next;

    // Scan: one enemy per cycle, accumulators only see live enemies
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            estado_reg <= VARRE;
            idx_reg    <= '0;
            min_x_reg  <= '1;
            max_x_reg  <= '0;
            max_yb_reg <= '0;
            cnt_reg    <= '0;
        end else if (reiniciarJogo) begin
            estado_reg <= VARRE;
            idx_reg    <= '0;
            min_x_reg  <= '1;
            max_x_reg  <= '0;
            max_yb_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            estado_reg <= estado_next;
            if (estado_reg == VARRE) begin
                idx_reg <= ultimo ? '0 : idx_reg + IW'(1);
                if (vivo_cur) begin
                    if (x_cur < min_x_reg)   min_x_reg  <= x_cur;
                    if (x_cur > max_x_reg)   max_x_reg  <= x_cur;
                    if (yb_cur > max_yb_reg) max_yb_reg <= yb_cur;
                    cnt_reg <= cnt_reg + VW'(1);
                end
            end else begin
                idx_reg    <= '0;
                min_x_reg  <= '1;
                max_x_reg  <= '0;
                max_yb_reg <= '0;
                cnt_reg    <= '0;
            end
        end
    end

    // Decision: direction only changes while CLOCK_MV stays high, so a flip
    // requested during the low phase waits for the next high phase.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            vivos_reg        <= VW'(N_INIMIGOS);
            todos_mortos_reg <= 1'b0;
            invasao_reg      <= 1'b0;
            sentido_reg      <= 1'b1;
            guarda_reg       <= 1'b0;
            periodo_pend_reg <= P_BASE;
        end else if (reiniciarJogo) begin
            vivos_reg        <= VW'(N_INIMIGOS);
            todos_mortos_reg <= 1'b0;
            invasao_reg      <= 1'b0;
            sentido_reg      <= 1'b1;
            guarda_reg       <= 1'b0;
            periodo_pend_reg <= P_BASE;
        end else begin
            if (queda) guarda_reg <= 1'b0;
            if (estado_reg == DECIDE) begin
                vivos_reg        <= cnt_reg;
                todos_mortos_reg <= (cnt_reg == '0);
                periodo_pend_reg <= periodo_calc;
                if (cnt_reg != '0) begin
                    if (32'(max_yb_reg) >= L_YLIM) invasao_reg <= 1'b1;
                    if (!guarda_reg && clock_mv_reg && !queda) begin
                        if (sentido_reg && borda_dir) begin
                            sentido_reg <= 1'b0;
                            guarda_reg  <= 1'b1;
                        end else if (!sentido_reg && borda_esq) begin
                            sentido_reg <= 1'b1;
                            guarda_reg  <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Tick generator: new period is only taken at wrap
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            contador_reg <= '0;
            periodo_reg  <= P_BASE;
            clock_mv_reg <= 1'b0;
        end else if (reiniciarJogo) begin
            contador_reg <= '0;
            periodo_reg  <= P_BASE;
            clock_mv_reg <= 1'b0;
        end else if (todos_mortos_reg) begin
            contador_reg <= '0;
            clock_mv_reg <= 1'b0;
        end else if (!pausa) begin
            clock_mv_reg <= mv_next;
            if (contador_reg >= periodo_reg - 32'd1) begin
                contador_reg <= '0;
                periodo_reg  <= periodo_pend_reg;
            end else begin
                contador_reg <= contador_reg + 32'd1;
            end
        end
    end

    assign CLOCK_MV     = clock_mv_reg;
    assign sentidoX     = sentido_reg;
    assign vivos        = vivos_reg;
    assign todos_mortos = todos_mortos_reg;
    assign invasao      = invasao_reg;

endmodule

// File: tb/tb_controle_formacao.sv
// Self-checking bench for controle_formacao with small timing parameters
// (N=4, base period 20, step 4, minimum 8).
module tb_controle_formacao;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        pausa;
    logic        reiniciarJogo;
    logic [39:0] x_bus;
    logic [39:0] y_bus;
    logic [3:0]  vivo_bus;
    logic        CLOCK_MV;
    logic        sentidoX;
    logic [2:0]  vivos;
    logic        todos_mortos;
    logic        invasao;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] obs;
    logic [31:0] exp_v;

    always #5 CLOCK_50 = ~CLOCK_50;

    controle_formacao #(
        .N_INIMIGOS(4),
        .PERIODO_BASE(20),
        .PASSO_PERIODO(4),
        .PERIODO_MIN(8)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .pausa(pausa),
        .reiniciarJogo(reiniciarJogo),
        .x_bus(x_bus),
        .y_bus(y_bus),
        .vivo_bus(vivo_bus),
        .CLOCK_MV(CLOCK_MV),
        .sentidoX(sentidoX),
        .vivos(vivos),
        .todos_mortos(todos_mortos),
        .invasao(invasao)
    );

    task automatic step();
        @(negedge CLOCK_50);
    endtask

    task automatic set_x(input int i, input int v);
        x_bus[10*i +: 10] = 10'(v);
    endtask

    task automatic set_y(input int i, input int v);
        y_bus[10*i +: 10] = 10'(v);
    endtask

    task automatic wait_mv(input logic lvl);
        int n = 0;
        while (CLOCK_MV !== lvl && n < 60) begin
            step();
            n++;
        end
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL wait_mv timeout: CLOCK_MV=%b required %b", CLOCK_MV, lvl);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; pausa = 1'b0; reiniciarJogo = 1'b0;
        x_bus = '0; y_bus = '0; vivo_bus = 4'hF;
        for (int i = 0; i < 4; i++) begin
            set_x(i, 100 * (i + 1));
            set_y(i, 50);
        end
        exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd4);
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        repeat (4) step();
        obs = 32'(CLOCK_MV); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_mv: got %0d required %0d", obs, exp_v); end
        obs = 32'(sentidoX); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_sentido: got %0d required %0d", obs, exp_v); end
        obs = 32'(vivos); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_vivos: got %0d required %0d", obs, exp_v); end
        obs = 32'(invasao); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_invasao: got %0d required %0d", obs, exp_v); end
        obs = 32'(todos_mortos); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_todos_mortos: got %0d required %0d", obs, exp_v); end
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_period_basic();
        int sx_bad = 0;
        reset = 1'b1;
        for (int i = 0; i < 40; i++) exp_q.push_back(((i % 20) < 10) ? 32'd1 : 32'd0);
        for (int i = 0; i < 40; i++) begin
            step();
            if (sentidoX !== 1'b1) sx_bad++;
            obs = 32'(CLOCK_MV); exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL period_base cycle %0d: CLOCK_MV=%0d required %0d", i, obs, exp_v); end
        end
        exp_q.push_back(32'd0);
        obs = 32'(sx_bad); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL period_base_sentido: changes=%0d required %0d", obs, exp_v); end
        $display("test_period_basic done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_edge_right();
        int bad = 0;
        int n = 0;
        int lat = 0;
        int trans = 0;
        logic prev;
        wait_mv(1'b1);
        wait_mv(1'b0);
        set_x(3, 600);
        exp_q.push_back(32'd0);
        while (CLOCK_MV === 1'b0 && n < 40) begin
            if (sentidoX !== 1'b1) bad++;
            step();
            n++;
        end
        obs = 32'(bad); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL right_deferred: early flips=%0d required %0d", obs, exp_v); end
        exp_q.push_back(32'd1); exp_q.push_back(32'd1);
        while (sentidoX !== 1'b0 && lat < 10) begin
            step();
            lat++;
        end
        obs = 32'(lat >= 1 && lat <= 5); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL right_flip_latency: latency=%0d required 1..5", lat); end
        obs = 32'(CLOCK_MV); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL right_flip_mv: CLOCK_MV=%0d required %0d", obs, exp_v); end
        exp_q.push_back(32'd0);
        prev = sentidoX;
        for (int i = 0; i < 40; i++) begin
            step();
            if (sentidoX !== prev) trans++;
            prev = sentidoX;
        end
        obs = 32'(trans); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL right_single_flip: extra flips=%0d required %0d", obs, exp_v); end
        $display("test_edge_right done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_edge_left();
        int bad = 0;
        int n = 0;
        set_x(3, 400);
        set_x(0, 11);
        vivo_bus = 4'b1110;
        exp_q.push_back(32'd0);
        for (int i = 0; i < 40; i++) begin
            step();
            if (sentidoX !== 1'b0) bad++;
        end
        obs = 32'(bad); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL left_dead_ignored: flips=%0d required %0d", obs, exp_v); end
        vivo_bus = 4'hF;
        exp_q.push_back(32'd1); exp_q.push_back(32'd1);
        while (sentidoX !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        obs = 32'(sentidoX); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL left_flip: sentidoX=%0d required %0d", obs, exp_v); end
        obs = 32'(CLOCK_MV); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL left_flip_mv: CLOCK_MV=%0d required %0d", obs, exp_v); end
        set_x(0, 100);
        $display("test_edge_left done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic measure_period(input int hi_req, input int lo_req);
        int hi = 0;
        int lo = 0;
        wait_mv(1'b0);
        wait_mv(1'b1);
        exp_q.push_back(32'(hi_req)); exp_q.push_back(32'(lo_req));
        while (CLOCK_MV === 1'b1 && hi < 40) begin step(); hi++; end
        while (CLOCK_MV === 1'b0 && lo < 40) begin step(); lo++; end
        obs = 32'(hi); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL period_high: cycles=%0d required %0d", obs, exp_v); end
        obs = 32'(lo); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL period_low: cycles=%0d required %0d", obs, exp_v); end
    endtask

    task automatic test_kill_period();
        int n = 0;
        int hi_cnt = 0;
        vivo_bus = 4'b0011;
        exp_q.push_back(32'd2);
        repeat (12) step();
        obs = 32'(vivos); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL kill2_vivos: got %0d required %0d", obs, exp_v); end
        measure_period(6, 6);
        vivo_bus = 4'b0001;
        exp_q.push_back(32'd1);
        repeat (12) step();
        obs = 32'(vivos); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL kill3_vivos: got %0d required %0d", obs, exp_v); end
        measure_period(4, 4);
        vivo_bus = 4'b0000;
        exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        while (todos_mortos !== 1'b1 && n < 12) begin step(); n++; end
        obs = 32'(todos_mortos); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL all_dead_flag: got %0d required %0d", obs, exp_v); end
        obs = 32'(vivos); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL all_dead_vivos: got %0d required %0d", obs, exp_v); end
        step();
        for (int i = 0; i < 30; i++) begin
            step();
            if (CLOCK_MV !== 1'b0) hi_cnt++;
        end
        obs = 32'(hi_cnt); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL all_dead_mv: high cycles=%0d required %0d", obs, exp_v); end
        vivo_bus = 4'hF;
        repeat (12) step();
        $display("test_kill_period done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_invasion();
        int n = 0;
        set_y(2, 380);
        vivo_bus = 4'b1011;
        exp_q.push_back(32'd0);
        repeat (20) step();
        obs = 32'(invasao); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL invasion_dead_ignored: got %0d required %0d", obs, exp_v); end
        vivo_bus = 4'hF;
        exp_q.push_back(32'd1);
        while (invasao !== 1'b1 && n < 15) begin step(); n++; end
        obs = 32'(invasao); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL invasion_set: got %0d required %0d", obs, exp_v); end
        vivo_bus = 4'b1011;
        set_y(2, 50);
        exp_q.push_back(32'd1);
        repeat (20) step();
        obs = 32'(invasao); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL invasion_sticky: got %0d required %0d", obs, exp_v); end
        vivo_bus = 4'hF;
        set_x(3, 600);
        n = 0;
        exp_q.push_back(32'd0);
        while (sentidoX !== 1'b0 && n < 60) begin step(); n++; end
        obs = 32'(sentidoX); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL restart_prep_flip: sentidoX=%0d required %0d", obs, exp_v); end
        set_x(3, 400);
        reiniciarJogo = 1'b1;
        exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd4);
        step();
        obs = 32'(invasao); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL restart_invasao: got %0d required %0d", obs, exp_v); end
        obs = 32'(sentidoX); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL restart_sentido: got %0d required %0d", obs, exp_v); end
        obs = 32'(CLOCK_MV); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL restart_mv: got %0d required %0d", obs, exp_v); end
        obs = 32'(vivos); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL restart_vivos: got %0d required %0d", obs, exp_v); end
        exp_q.push_back(32'd0);
        repeat (6) step();
        obs = 32'(CLOCK_MV); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL restart_hold_mv: got %0d required %0d", obs, exp_v); end
        reiniciarJogo = 1'b0;
        $display("test_invasion done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_pause();
        int bad = 0;
        int n = 0;
        wait_mv(1'b0);
        wait_mv(1'b1);
        repeat (5) step();
        pausa = 1'b1;
        exp_q.push_back(32'd0);
        for (int i = 0; i < 50; i++) begin
            step();
            if (CLOCK_MV !== 1'b1) bad++;
        end
        obs = 32'(bad); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL pause_hold: low cycles=%0d required %0d", obs, exp_v); end
        pausa = 1'b0;
        exp_q.push_back(32'd5);
        while (CLOCK_MV === 1'b1 && n < 40) begin step(); n++; end
        obs = 32'(n); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL pause_resume_fall: cycles=%0d required %0d", obs, exp_v); end
        $display("test_pause done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_async_reset();
        set_y(0, 390);
        vivo_bus = 4'b0111;
        exp_q.push_back(32'd1); exp_q.push_back(32'd3);
        repeat (15) step();
        obs = 32'(invasao); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL pre_reset_invasao: got %0d required %0d", obs, exp_v); end
        obs = 32'(vivos); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL pre_reset_vivos: got %0d required %0d", obs, exp_v); end
        wait_mv(1'b1);
        #2 reset = 1'b0;
        exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd4);
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        obs = 32'(CLOCK_MV); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL async_reset_mv: got %0d required %0d", obs, exp_v); end
        obs = 32'(sentidoX); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL async_reset_sentido: got %0d required %0d", obs, exp_v); end
        obs = 32'(vivos); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL async_reset_vivos: got %0d required %0d", obs, exp_v); end
        obs = 32'(invasao); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL async_reset_invasao: got %0d required %0d", obs, exp_v); end
        obs = 32'(todos_mortos); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL async_reset_todos_mortos: got %0d required %0d", obs, exp_v); end
        step();
        reset = 1'b1;
        step();
        $display("test_async_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        test_reset();
        test_period_basic();
        test_edge_right();
        test_edge_left();
        test_kill_period();
        test_invasion();
        test_pause();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/controle_formacao.md
Name: controle_formacao

Overview:
Formation controller for the enemy array. It sits directly upstream of every enemy instance and generates the shared movement clock CLOCK_MV and the horizontal direction sentidoX. It scans the packed enemy positions and alive flags, flips direction when the formation reaches a screen edge, and shortens the movement period as enemies die. It also flags invasion and flags an empty formation for the game FSM.

Parameters:
N_INIMIGOS, 8, number of enemy instances scanned
PERIODO_BASE, 1000000, CLOCK_50 cycles per movement step with all enemies alive
PASSO_PERIODO, 100000, period reduction per dead enemy
PERIODO_MIN, 200000, lower bound on the period
X_MIN_TELA, 10, left screen limit (pixels)
X_MAX_TELA, 630, right screen limit (pixels)
LARGURA, 33, enemy width
ALTURA, 24, enemy height
PASSO_X, 2, enemy x step per movement tick
Y_LIMITE, 400, invasion line

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low; 0 = reset
pausa  in  1  1 = freeze movement timing
reiniciarJogo  in  1  synchronous game restart, 1-cycle or level
x_bus  in  10*N_INIMIGOS  packed enemy x; enemy i at bits [10i+9:10i]
y_bus  in  10*N_INIMIGOS  packed enemy y, same packing as x_bus
vivo_bus  in  N_INIMIGOS  enemy alive flags
CLOCK_MV  out  1  movement clock; enemies step on its falling edge
sentidoX  out  1  1 = right, 0 = left
vivos  out  clog2(N_INIMIGOS+1)  alive count from the last completed scan
todos_mortos  out  1  1 when vivos == 0
invasao  out  1  sticky; a live enemy reached Y_LIMITE

Behaviour:
- Reset (reset=0, async): CLOCK_MV=0, sentidoX=1, vivos=N_INIMIGOS, todos_mortos=0, invasao=0, period=PERIODO_BASE, counter=0, scan index=0, flip-guard=0.
- reiniciarJogo=1 (sync): same values as reset. It holds them while asserted. sentidoX is 1 so enemies reinitialise with sentidoAtual=1.
- Scan FSM, two states, runs continuously, including during pausa:
  - VARRE: one enemy per cycle, index 0..N-1. For live enemies only, accumulate min_x, max_x, max y+ALTURA, and count.
  - DECIDE: one cycle. Latch vivos and todos_mortos, evaluate edge/invasion, compute next period, clear accumulators, return to VARRE at index 0.
  - Scan latency is N+1 cycles.
- Edge rule, evaluated in DECIDE only if count>0 and flip-guard=0:
  - sentidoX=1 and max_x+LARGURA+PASSO_X > X_MAX_TELA → sentidoX=0, flip-guard=1.
  - sentidoX=0 and min_x < X_MIN_TELA+PASSO_X → sentidoX=1, flip-guard=1.
  - At most one flip per movement period. flip-guard clears on the CLOCK_MV falling edge.
  - sentidoX changes only while CLOCK_MV=1. A flip due while CLOCK_MV=0 is deferred to the first DECIDE with CLOCK_MV=1.
- Invasion: in DECIDE, if any live enemy has y+ALTURA >= Y_LIMITE, set invasao=1. It stays 1 until reset or reiniciarJogo. Dead enemies are ignored.
- Period:
  - mortos = N-count.
  - next = PERIODO_BASE - mortos*PASSO_PERIODO.
  - If PERIODO_BASE < mortos*PASSO_PERIODO + PERIODO_MIN, next = PERIODO_MIN.
  - Use 32-bit arithmetic with no underflow.
  - next is applied only at counter wrap, never mid-period.
- Tick generator:
  - 32-bit counter increments each cycle while pausa=0 and todos_mortos=0.
  - Counter wraps to 0 at period-1.
  - CLOCK_MV (registered) = 1 while counter < period/2 (floor), else 0. One falling edge per period.
- pausa=1: counter and CLOCK_MV hold their values. No edge is produced. Scan, vivos and invasao keep updating.
- todos_mortos=1: counter forced to 0, CLOCK_MV forced to 0. No further edges until count>0 or restart.
- No live enemies during a scan: min/max, direction and invasao are unchanged.
- The block does not resynchronise the input buses; they are in the CLOCK_50 domain.

Test Plan:
Use test parameters N_INIMIGOS=4, PERIODO_BASE=20, PASSO_PERIODO=4, PERIODO_MIN=8.
1. Reset hold, then release with all alive and x=100..400 → during reset CLOCK_MV=0, sentidoX=1, vivos=4, invasao=0. After release, CLOCK_MV is 1 for 10 cycles then 0 for 10, repeating, with sentidoX constant.
2. sentidoX=1, max live x=600 (600+33+2=635>630) → sentidoX=0 within 5 cycles while CLOCK_MV=1. Exactly one flip per period with positions held.
3. sentidoX=0, min live x=11 (<12) → sentidoX=1. Same x=11 on a dead enemy → no flip.
4. Kill 2 enemies → vivos=2; from the next wrap the period is 12 (high 6). Kill 1 more → 8. Kill the last → todos_mortos=1, CLOCK_MV=0 and stays 0.
5. Live enemy y=380 (404>=400) → invasao=1, which persists after that enemy dies. Dead enemy with y=380 → invasao stays 0. reiniciarJogo → invasao=0, sentidoX=1.
6. pausa=1 for 50 cycles at counter=5 → CLOCK_MV stays 1 throughout. After release, the falling edge occurs 5 cycles later. Assert reset mid-period → all outputs take reset values immediately, asynchronously.
